// File: rtl/pixel_stream_proc.sv
// rtl/pixel_stream_proc.sv - bottom-up frame reader with per-pixel colour ops and 2-entry output FIFO
module pixel_stream_proc #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int PPC    = 2,
  parameter int AW     = 18
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                sign,
  input  logic [7:0]          value,
  input  logic [7:0]          threshold,
  output logic                mem_rd,
  output logic [AW-1:0]       mem_addr,
  input  logic [24*PPC-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [24*PPC-1:0]   out_data,
  output logic                out_eol,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int WPR = WIDTH / PPC;
  localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DW  = 24 * PPC;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]    cfg_mode;
  logic          cfg_sign;
  logic [7:0]    cfg_value;
  logic [7:0]    cfg_thr;

  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          rd_fin;
  logic          rd_eol;
  logic          rd_last;
  logic [AW-1:0] rd_addr;

  logic          infl;
  logic          infl_eol;
  logic          infl_last;

  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_eol;
  logic [1:0]    fifo_last;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    occ_net;
  logic          pop;
  logic          last_seen;
  logic [DW-1:0] proc_data;

  function automatic logic [23:0] pix_op(input logic [23:0] p, input logic [1:0] md,
                                         input logic sg, input logic [7:0] v, input logic [7:0] thr);
    logic [9:0]  sum;
    logic [7:0]  avg;
    logic [8:0]  t;
    logic [23:0] r;
    sum = {2'b00, p[23:16]} + {2'b00, p[15:8]} + {2'b00, p[7:0]};
    avg = 8'(sum / 10'd3);
    r   = p;
    case (md)
      2'd1: begin
        for (int c = 0; c < 3; c++) begin
          if (sg) begin
            t = {1'b0, p[8*c +: 8]} + {1'b0, v};
            r[8*c +: 8] = t[8] ? 8'hFF : t[7:0];
          end else begin
            r[8*c +: 8] = (p[8*c +: 8] < v) ? 8'd0 : p[8*c +: 8] - v;
          end
        end
      end
      2'd2:    r = {3{8'd255 - avg}};
      2'd3:    r = (avg > thr) ? 24'hFFFFFF : 24'h000000;
      default: r = p;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic and status outputs; RUN exits one cycle after the last beat is taken
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_seen) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Configuration is captured only on frame start so mid-frame changes cannot leak in
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cfg_mode  <= '0;
      cfg_sign  <= 1'b0;
      cfg_value <= '0;
      cfg_thr   <= '0;
    end else if (state == IDLE && start) begin
      cfg_mode  <= mode;
      cfg_sign  <= sign;
      cfg_value <= value;
      cfg_thr   <= threshold;
    end
  end

  // Read issue: credit counts FIFO entries left after this cycle's pop plus the read in flight
  always_comb begin
    pop       = out_valid && out_ready;
    occ_net   = count - {1'b0, pop} + {1'b0, infl};
    rd_eol    = (rd_col == CW'(WPR - 1));
    rd_last   = rd_eol && (rd_row == RW'(HEIGHT - 1));
    rd_addr   = (AW'(HEIGHT - 1) - AW'(rd_row)) * AW'(WPR) + AW'(rd_col);
    mem_rd    = (state == RUN) && !rd_fin && (occ_net < 2'd2);
    mem_addr  = mem_rd ? rd_addr : '0;
    out_valid = (count != 2'd0);
    out_data  = fifo_data[rd_ptr];
    out_eol   = out_valid && fifo_eol[rd_ptr];
    out_last  = out_valid && fifo_last[rd_ptr];
  end

  // Row/column walk of the read side; rows are fetched bottom-up from memory
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_row <= '0;
      rd_col <= '0;
      rd_fin <= 1'b0;
    end else if (state == IDLE && start) begin
      rd_row <= '0;
      rd_col <= '0;
      rd_fin <= 1'b0;
    end else if (mem_rd) begin
      if (rd_eol) begin
        rd_col <= '0;
        if (rd_last) rd_fin <= 1'b1;
        else         rd_row <= rd_row + 1'b1;
      end else begin
        rd_col <= rd_col + 1'b1;
      end
    end
  end

  // Track the single read whose data returns next cycle, with its row/frame markers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      infl      <= 1'b0;
      infl_eol  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl      <= mem_rd;
      infl_eol  <= rd_eol;
      infl_last <= rd_last;
    end
  end

  // Per-lane pixel processing applied to returning read data
  always_comb begin
    proc_data = '0;
    for (int k = 0; k < PPC; k++)
      proc_data[24*k +: 24] = pix_op(mem_rdata[24*k +: 24], cfg_mode, cfg_sign, cfg_value, cfg_thr);
  end

  // Two-entry output FIFO holding processed beats and their markers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_eol     <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
    end else begin
      if (infl) begin
        fifo_data[wr_ptr] <= proc_data;
        fifo_eol[wr_ptr]  <= infl_eol;
        fifo_last[wr_ptr] <= infl_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= occ_net;
    end
  end

  // Remember that the final beat was accepted so RUN can close out next cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) last_seen <= 1'b0;
    else          last_seen <= (state == RUN) && pop && out_last;
  end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// tb/tb_pixel_stream_proc.sv - scoreboard bench for pixel_stream_proc with randomized frames
module tb_pixel_stream_proc;

  localparam int W = 8;
  localparam int H = 2;
  localparam int P = 2;
  localparam int WPR = W / P;
  localparam int NB = W * H / P;

  logic        HCLK, HRESETn;
  logic        start, sign, out_ready;
  logic [1:0]  mode;
  logic [7:0]  value, threshold;
  logic        mem_rd, out_valid, out_eol, out_last, busy, done;
  logic [5:0]  mem_addr;
  logic [47:0] mem_rdata, out_data;

  logic        t_start, t_rd, t_valid, t_eol, t_last, t_busy, t_done;
  logic [3:0]  t_addr;
  logic [23:0] t_rdata, t_data;

  logic [47:0] mem [8];

  typedef struct {
    logic [47:0] data;
    bit          eol;
    bit          last;
  } beat_t;
  beat_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, outst = 0, done_due = -1, done_cnt = 0, hs_total = 0;
  int first_hs_cyc = 0, last_hs_cyc = 0;
  bit frame_first = 0, stall_prev = 0, hs = 0;
  logic [49:0] held;
  beat_t e;

  pixel_stream_proc #(.WIDTH(W), .HEIGHT(H), .PPC(P), .AW(6)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .sign(sign),
    .value(value), .threshold(threshold), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done)
  );

  pixel_stream_proc #(.WIDTH(1), .HEIGHT(1), .PPC(1), .AW(4)) dut_tiny (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(t_start), .mode(2'd0), .sign(1'b0),
    .value(8'd0), .threshold(8'd0), .mem_rd(t_rd), .mem_addr(t_addr),
    .mem_rdata(t_rdata), .out_valid(t_valid), .out_ready(1'b1),
    .out_data(t_data), .out_eol(t_eol), .out_last(t_last), .busy(t_busy), .done(t_done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // memory models: data valid the cycle after the strobe, garbage otherwise
  always @(posedge HCLK) begin
    mem_rdata <= mem_rd ? mem[mem_addr[2:0]] : 48'({$urandom(), $urandom()});
    t_rdata   <= t_rd ? 24'h5A3C81 : 24'($urandom());
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_pix(input logic [23:0] p, input int md, input int sg,
                                          input int vl, input int th);
    int ch[3];
    int avg;
    ch[0] = int'(p[23:16]);
    ch[1] = int'(p[15:8]);
    ch[2] = int'(p[7:0]);
    avg = (ch[0] + ch[1] + ch[2]) / 3;
    for (int i = 0; i < 3; i++) begin
      case (md)
        1: ch[i] = sg ? ((ch[i] + vl > 255) ? 255 : ch[i] + vl) : ((ch[i] - vl < 0) ? 0 : ch[i] - vl);
        2: ch[i] = 255 - avg;
        3: ch[i] = (avg > th) ? 255 : 0;
        default: ch[i] = ch[i];
      endcase
    end
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  task automatic push_model(input int md, input int sg, input int vl, input int th);
    beat_t b;
    int w;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < WPR; c++) begin
        w = (H - 1 - r) * WPR + c;
        b.data = {ref_pix(mem[w][47:24], md, sg, vl, th), ref_pix(mem[w][23:0], md, sg, vl, th)};
        b.eol  = (c == WPR - 1);
        b.last = (c == WPR - 1) && (r == H - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic push_same(input logic [47:0] d);
    beat_t b;
    for (int i = 0; i < NB; i++) begin
      b.data = d;
      b.eol  = (i % WPR == WPR - 1);
      b.last = (i == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic churn(input bit bp);
    start     = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    mode      = 2'($urandom_range(0, 3));
    sign      = 1'($urandom_range(0, 1));
    value     = 8'($urandom());
    threshold = 8'($urandom());
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // monitor: pops the scoreboard on each handshake and watches flow-control rules
  always @(negedge HCLK) begin
    cyc++;
    if (!HRESETn) begin
      outst = 0; stall_prev = 0; done_due = -1;
    end else begin
      hs = out_valid && out_ready;
      if (mem_rd) chk("rd_window", ((outst - int'(hs)) < 2) ? 1 : 0, 1);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", {out_data, out_eol, out_last}, held);
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_beat: got beat %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_eol", out_eol, e.eol);
          chk("beat_last", out_last, e.last);
        end
        if (frame_first) begin first_hs_cyc = cyc; frame_first = 0; end
        last_hs_cyc = cyc;
        hs_total++;
        if (out_last) done_due = cyc + 2;
      end
      if (done) begin
        chk("done_timing", cyc, done_due);
        done_cnt++;
        done_due = -1;
      end
      outst = outst + int'(mem_rd) - int'(hs);
      stall_prev = out_valid && !out_ready;
      held = {out_data, out_eol, out_last};
    end
  end

  task automatic run_frame(input int md, input int sg, input int vl, input int th,
                           input bit bp, input bit use_model);
    int d0, budget;
    if (use_model) push_model(md, sg, vl, th);
    d0 = done_cnt;
    @(posedge HCLK); #1;
    mode = 2'(md); sign = 1'(sg); value = 8'(vl); threshold = 8'(th);
    start = 1'b1; out_ready = 1'b1; frame_first = 1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge HCLK); #1;
      churn(bp);
      @(negedge HCLK);
      if (k == 1) begin
        chk("first_rd", mem_rd, 1);
        chk("first_addr", mem_addr, (H - 1) * WPR);
      end
      if (k == 2) chk("valid_c2", out_valid, 0);
      if (k == 3) chk("valid_c3", out_valid, 1);
    end
    budget = 400;
    while (budget > 0) begin
      @(posedge HCLK); #1;
      if (done_cnt != d0) break;
      churn(bp);
      budget--;
    end
    start = 1'b0; out_ready = 1'b1;
    if (budget == 0) begin
      chk("frame_timeout", done_cnt, d0 + 1);
      exp_q.delete();
    end
    chk("frame_q_empty", exp_q.size(), 0);
    if (!bp) chk("full_rate", last_hs_cyc - first_hs_cyc, NB - 1);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_rd"}, mem_rd, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_eol"}, out_eol, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    int h0, beats, dn;
    HRESETn = 1'b0; start = 1'b0; mode = 2'd0; sign = 1'b0; value = 8'd0;
    threshold = 8'd0; out_ready = 1'b1; t_start = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;
    check_quiet("reset");
    @(posedge HCLK); #1 HRESETn = 1'b1;

    // word n = n, pass-through, words come back bottom row first
    for (int i = 0; i < 8; i++) mem[i] = 48'(i);
    for (int i = 0; i < NB; i++) begin
      e.data = 48'((i + WPR) % NB);
      e.eol  = (i % WPR == WPR - 1);
      e.last = (i == NB - 1);
      exp_q.push_back(e);
    end
    run_frame(0, 0, 0, 0, 1'b0, 1'b0);

    // lane1 = (30,60,91), lane0 = (200,10,255)
    for (int i = 0; i < 8; i++) mem[i] = {24'h1E3C5B, 24'hC80AFF};
    push_same({24'h82A0BF, 24'hFF6EFF}); run_frame(1, 1, 100, 0, 1'b0, 1'b0);
    push_same({24'h000000, 24'h64009B}); run_frame(1, 0, 100, 0, 1'b1, 1'b0);
    push_same({24'hC3C3C3, 24'h646464}); run_frame(2, 0, 0, 0, 1'b1, 1'b0);
    push_same({24'h000000, 24'hFFFFFF}); run_frame(3, 0, 0, 60, 1'b1, 1'b0);
    push_same({24'hFFFFFF, 24'hFFFFFF}); run_frame(3, 0, 0, 59, 1'b1, 1'b0);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 8; i++) mem[i] = 48'({$urandom(), $urandom()});
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1, 1'b1);
    end

    // reset during the fifth beat, then a fresh frame must restart at row 0
    for (int i = 0; i < 8; i++) mem[i] = 48'({$urandom(), $urandom()});
    push_model(1, 1, 40, 0);
    h0 = hs_total;
    @(posedge HCLK); #1;
    mode = 2'd1; sign = 1'b1; value = 8'd40; start = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 60 && (hs_total - h0) < 4; k++) begin
      @(posedge HCLK); #1;
      churn(1'b1);
    end
    chk("pre_reset_beats", hs_total - h0, 4);
    #2 HRESETn = 1'b0;
    #1 check_quiet("mid_reset");
    exp_q.delete();
    dn = done_cnt;
    repeat (3) @(posedge HCLK);
    #1 start = 1'b0; HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    chk("no_done_after_abort", done_cnt, dn);
    run_frame(0, 0, 0, 0, 1'b1, 1'b1);

    // 1x1 frame on the single-pixel instance
    beats = 0; dn = 0;
    @(posedge HCLK); #1 t_start = 1'b1;
    @(posedge HCLK); #1 t_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if (t_valid) begin
        beats++;
        chk("tiny_data", t_data, 24'h5A3C81);
        chk("tiny_eol", t_eol, 1);
        chk("tiny_last", t_last, 1);
      end
      if (t_done) dn++;
    end
    chk("tiny_beats", beats, 1);
    chk("tiny_done", dn, 1);
    chk("tiny_idle", t_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_proc.md
PIXEL_STREAM_PROC -- requirements
Module: pixel_stream_proc

Interface
REQ-001 Parameter WIDTH, default 768, meaning pixels per row; SHALL be a multiple of PPC.
REQ-002 Parameter HEIGHT, default 512, meaning rows per frame.
REQ-003 Parameter PPC, default 2, meaning pixels per beat; legal values 1, 2, 4.
REQ-004 Parameter AW, default 18, meaning memory word-address width.
REQ-005 Port HCLK, input, 1, clock; all state SHALL update on its rising edge.
REQ-006 Port HRESETn, input, 1, reset; asynchronous, active-low.
REQ-007 Port start, input, 1, frame start request.
REQ-008 Port mode, input, 2, operation select: 0 pass, 1 brightness, 2 invert, 3 threshold.
REQ-009 Port sign, input, 1, brightness direction: 1 add, 0 subtract.
REQ-010 Port value, input, 8, brightness offset.
REQ-011 Port threshold, input, 8, threshold level.
REQ-012 Port mem_rd, output, 1, memory read strobe.
REQ-013 Port mem_addr, output, AW, word address; one word holds PPC pixels.
REQ-014 Port mem_rdata, input, 24*PPC, read data, valid exactly 1 cycle after mem_rd; pixel k at bits [24k+23:24k], ordered R[23:16], G[15:8], B[7:0].
REQ-015 Port out_valid, output, 1, output beat valid.
REQ-016 Port out_ready, input, 1, sink accept.
REQ-017 Port out_data, output, 24*PPC, processed pixels, same packing as mem_rdata.
REQ-018 Port out_eol, output, 1, beat is the last of a row.
REQ-019 Port out_last, output, 1, beat is the last of the frame.
REQ-020 Port busy, output, 1, high from IDLE exit until return to IDLE.
REQ-021 Port done, output, 1, single-cycle end-of-frame pulse.

Function
REQ-022 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE in the cycle after the out_last beat handshakes.
- DONE -> IDLE unconditionally after 1 cycle, with done=1 in DONE.
REQ-023 On the IDLE->RUN edge, the block SHALL latch mode, sign, value and threshold; input changes during RUN SHALL have no effect.
REQ-024 start SHALL be ignored in RUN and DONE.
REQ-025 Output row r (0 = first emitted) SHALL read memory row HEIGHT-1-r (bottom-up frame storage).
- Word address = ((HEIGHT-1-r)*WIDTH + c)/PPC.
- c advances by PPC per beat and wraps to 0 at WIDTH, incrementing r.
REQ-026 The output SHALL be buffered by a 2-entry FIFO. mem_rd SHALL assert only when (FIFO occupancy + reads in flight) < 2 and frame words remain.
- The sustained rate SHALL be 1 beat/cycle while out_ready=1.
- Latency from start to first out_valid SHALL be 3 cycles.
REQ-027 out_data, out_eol and out_last SHALL remain stable while out_valid=1 and out_ready=0.
- A handshake occurs when out_valid=1 and out_ready=1.
REQ-028 Per-pixel operations:
- mode 0: output = input.
- mode 1, sign 1: each channel = min(ch+value, 255).
- mode 1, sign 0: each channel = max(ch-value, 0).
- mode 2: avg = floor((R+G+B)/3) computed at 10 bits; R = G = B = 255-avg.
- mode 3: R = G = B = (avg > threshold) ? 255 : 0.
REQ-029 Exactly WIDTH*HEIGHT/PPC beats SHALL be emitted per frame.
- out_eol SHALL assert on every WIDTH/PPC-th beat.
- out_last SHALL assert on the final beat only, together with out_eol.
REQ-030 A frame of size 1x1 with PPC=1 SHALL produce one beat with out_eol=out_last=1.

Reset
REQ-031 Asserting HRESETn low SHALL immediately force:
- state to IDLE and the FIFO to empty, discarding in-flight reads;
- row and column counters to 0;
- mem_rd, out_valid, out_eol, out_last, busy and done to 0;
- mem_addr and out_data to 0;
- the latched configuration to 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse; the next start after release SHALL begin at row 0, column 0.

Verification
REQ-033 WIDTH=8, HEIGHT=2, PPC=2, mode 0, out_ready=1: memory word n = n -> 8 beats carrying words 4,5,6,7,0,1,2,3; out_eol on beats 4 and 8; out_last on beat 8; done 2 cycles after the last beat.
REQ-034 Brightness: pixel (200,10,255), value=100. With sign=1 -> (255,110,255). With sign=0 -> (100,0,155).
REQ-035 Grey ops on pixel (30,60,91), avg 60. mode 2 -> (195,195,195). mode 3 with threshold=60 -> (0,0,0). mode 3 with threshold=59 -> (255,255,255).
REQ-036 Backpressure: out_ready toggles 1,0,0,1 randomly -> no beat lost or duplicated; data held stable while stalled; mem_rd never asserted when 2 entries are occupied or pending.
REQ-037 Config change mid-frame (mode 1 -> 3 after beat 2) -> all beats still processed as mode 1; start pulse during RUN -> ignored, exactly 8 beats.
REQ-038 HRESETn low at beat 5, then start after release -> all outputs 0 during reset, no done pulse, new frame begins at word 4 (row 0).
